// File: rtl/pipe_reg_chain_pkg.sv
// Shared helpers for the register-chain pipeline.
// Only the occupancy counter width lives here; everything else is local to the blocks.
package pipe_reg_chain_pkg;

  // Bits needed to count 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One {valid, data} slot of the chain; updates in one cycle, holds while not advancing.
// Flush clears only the valid bit so stale data stays parked until overwritten.
module pipe_stage #(
  parameter int BITWIDTH = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                flush,
  input  logic                advance,
  input  logic                load,
  input  logic                in_valid,
  input  logic [BITWIDTH-1:0] in_data,
  output logic                valid,
  output logic [BITWIDTH-1:0] data
);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      if (flush) begin
        valid <= 1'b0;
      end else if (advance) begin
        valid <= in_valid;
      end
      if (load && !flush) begin
        data <= in_data;
      end
    end
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage valid/ready register chain, DEPTH cycles latency, full throughput.
// Backpressure ripples combinationally from OUT_READY; empty stages always accept (bubbles collapse).
module pipe_reg_chain
  import pipe_reg_chain_pkg::*;
#(
  parameter int BITWIDTH = 8,
  parameter int DEPTH    = 3
) (
  input  logic                        CLK,
  input  logic                        RSTN,
  input  logic                        FLUSH,
  input  logic                        IN_VALID,
  output logic                        IN_READY,
  input  logic [BITWIDTH-1:0]         IN_DATA,
  output logic                        OUT_VALID,
  input  logic                        OUT_READY,
  output logic [BITWIDTH-1:0]         OUT_DATA,
  output logic [cnt_width(DEPTH)-1:0] COUNT
);

  localparam int CW = cnt_width(DEPTH);

  logic [DEPTH:0]      adv;
  logic [DEPTH-1:0]    vld;
  logic [BITWIDTH-1:0] dat [DEPTH];
  logic                in_hs;
  logic                out_hs;

  // adv[DEPTH] stands in for the downstream consumer.
  assign adv[DEPTH] = OUT_READY;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    assign adv[i] = ~vld[i] | adv[i+1];

    if (i == 0) begin : g_head
      pipe_stage #(.BITWIDTH(BITWIDTH)) u_stage (
        .clk      (CLK),
        .rstn     (RSTN),
        .flush    (FLUSH),
        .advance  (adv[0]),
        .load     (adv[0] & IN_VALID),
        .in_valid (IN_VALID),
        .in_data  (IN_DATA),
        .valid    (vld[0]),
        .data     (dat[0])
      );
    end else begin : g_body
      pipe_stage #(.BITWIDTH(BITWIDTH)) u_stage (
        .clk      (CLK),
        .rstn     (RSTN),
        .flush    (FLUSH),
        .advance  (adv[i]),
        .load     (adv[i] & vld[i-1]),
        .in_valid (vld[i-1]),
        .in_data  (dat[i-1]),
        .valid    (vld[i]),
        .data     (dat[i])
      );
    end
  end

  assign IN_READY  = adv[0] & ~FLUSH;
  assign OUT_VALID = vld[DEPTH-1] & ~FLUSH;
  assign OUT_DATA  = dat[DEPTH-1];

  assign in_hs  = IN_VALID & IN_READY;
  assign out_hs = OUT_VALID & OUT_READY;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      COUNT <= '0;
    end else if (FLUSH) begin
      COUNT <= '0;
    end else if (in_hs && !out_hs) begin
      COUNT <= COUNT + CW'(1);
    end else if (out_hs && !in_hs) begin
      COUNT <= COUNT - CW'(1);
    end
  end

endmodule
